// File: rtl/operand_fifo.sv
// Operand-pair FIFO feeding the reduction stage: first-word-fall-through,
// occupancy held in a dedicated counter, head zeroed when empty.
module operand_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic                       s_valid,
    input  logic [WIDTH-1:0]           s_in1,
    input  logic [WIDTH-1:0]           s_in2,
    output logic                       s_ready,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           in1,
    output logic [WIDTH-1:0]           in2,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               push, pop;

    assign s_ready = RESETN && (count_q != CW'(DEPTH));
    assign m_valid = (count_q != '0);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign count   = count_q;

    assign in1 = m_valid ? mem_q[rd_ptr_q][2*WIDTH-1:WIDTH] : '0;
    assign in2 = m_valid ? mem_q[rd_ptr_q][WIDTH-1:0]       : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; count gates its visibility.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= {s_in1, s_in2};
    end

endmodule
